alu_nbit_seq: RTL and testbench
===============================

// Module: alu_nbit_seq
// PURPOSE
//  Parametrised, registered successor to the 4-bit combinational ALU.
//  Operand widths are set by WIDTH. The block accepts one operation per valid/ready handshake and returns a result with flags.
//  It holds a single-entry output register, and its FSM supports iterative multi-cycle shifts.
//  It sits between the processor decode stage and the register-file write-back.
// PARAMETERS
//  WIDTH  4  operand/result width in bits; legal values >= 2
//  SHW    $clog2(WIDTH)  shift-amount width; derived, do not override
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      op/a/b/cin are valid
//  in_ready   out  1      block can accept an operation this cycle
//  op         in   4      operation code (see BEHAVIOUR)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts
//  cin        in   1      carry/borrow in
//  out_valid  out  1      f and the flags are valid
//  out_ready  in   1      consumer takes the result this cycle
//  f          out  WIDTH  result
//  cout       out  1      carry out / last bit shifted out
//  zero       out  1      f == 0
//  neg        out  1      f[WIDTH-1]
//  ovf        out  1      signed overflow (arith ops only, else 0)
//  illegal    out  1      op is not supported in this build
// BEHAVIOUR
//  Reset: all outputs 0 except in_ready = 1; state = IDLE; shift counter = 0.
//  Ops:
//    0000 a+cin       0001 a+b+cin       0010 a+~b+1 (a-b)   0011 a+~b+!cin (a-b-cin)
//    0100 a&b         0101 a|b           0110 a^b            0111 ~a
//    1000 SHL a by b[SHW-1:0]   1001 SHR logical   others: illegal
//  Arithmetic: all sums are computed at WIDTH+1 bits; cout = bit WIDTH.
//    For subtraction, cout = 1 means no borrow.
//    ovf = (sA==sB') && (sF!=sA), where B' is the effective addend.
//  Logic ops: cout = 0, ovf = 0.
//  Handshake: an operation is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
//  in_ready = (state==IDLE) && (!out_valid || out_ready). Accept and drain in the same cycle are allowed.
//  Single-cycle ops have latency 1: the result is registered and out_valid = 1 on the edge after acceptance.
//  FSM states:
//    IDLE -> EXEC on accepting a shift with shamt != 0. Otherwise stay in IDLE and load the output register.
//    EXEC: shift the working register by 1 bit per cycle; cout captures the bit shifted out; decrement the counter.
//    EXEC -> IDLE when the counter reaches 0. On that edge, load f/flags and set out_valid.
//    A shift with shamt = 0 takes latency 1: f = a, cout = 0. A shift with shamt = k takes latency k+1.
//  out_valid, f and flags hold stable while out_valid && !out_ready. in_ready = 0 during EXEC.
//  Reset mid-EXEC aborts the operation; the partial result is discarded and no out_valid is produced.
// CONFIGURATION
//  Macro ALU_NBIT_SHIFT_EN.
//  Defined: ops 1000/1001 are supported and the EXEC state exists.
//  Undefined: the FSM never leaves IDLE. Ops 1xxx complete in 1 cycle with f = 0, flags = 0, illegal = 1.
//  illegal is always 1 for ops 1010..1111 regardless of the macro.
// TESTING (WIDTH=4, SHIFT_EN defined unless noted)
//  1 op=0001 a=0111 b=1001 cin=0 -> 1 cycle later f=0000 cout=1 zero=1 ovf=0.
//  2 op=0010 a=0011 b=0101 -> f=1110 cout=0 neg=1 ovf=0. op=0001 a=0111 b=0001 cin=0 -> f=1000 ovf=1.
//  3 out_ready=0, issue two ops back-to-back -> first accepted, in_ready drops, f held stable.
//    After out_ready=1 for one cycle -> second op accepted in that same cycle.
//  4 op=1000 a=0011 b=0010 -> in_ready=0 for 2 cycles, out_valid on cycle 3, f=1100 cout=0.
//    op=1001 a=1001 b=0001 -> f=0100 cout=1.
//  5 rst_n low during EXEC of a 3-bit shift -> out_valid=0, in_ready=1, no stale result after release.
//  6 Macro undefined: op=1000 -> 1 cycle later f=0000 illegal=1. op=0110 a=1010 b=0110 -> f=1100 illegal=0.

Source files
------------

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and iterative multi-cycle shifts.
// Define ALU_NBIT_SHIFT_EN to enable SHL/SHR (ops 1000/1001) and the EXEC state.
module alu_nbit_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             illegal
);

    localparam int SHW = $clog2(WIDTH);

    // Handshake: an op is taken on a clock edge where in_valid && in_ready; a result
    // leaves on an edge where out_valid && out_ready. Both may happen on the same edge.

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_f;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;
    logic             r_illegal;

    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_shr;

    logic [WIDTH-1:0] w_addend;
    logic             w_carry;
    logic             w_is_arith;
    logic             w_is_shift;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic             w_illegal;
    logic [SHW-1:0]   w_shamt;
    logic             w_go_exec;

    logic             w_in_ready;
    logic             w_load_single;
    logic             w_start_shift;
    logic             w_shift_step;
    logic             w_shift_done;
    logic [WIDTH-1:0] w_work_nxt;
    logic             w_shout;

    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_addend   = '0;
        w_carry    = 1'b0;
        w_is_arith = 1'b0;
        w_is_shift = 1'b0;
        w_res      = '0;
        w_cout     = 1'b0;
        w_ovf      = 1'b0;
        w_illegal  = 1'b0;
        case (op)
            4'b0000: begin
                w_is_arith = 1'b1;
                w_carry    = cin;
            end
            4'b0001: begin
                w_is_arith = 1'b1;
                w_addend   = b;
                w_carry    = cin;
            end
            4'b0010: begin
                w_is_arith = 1'b1;
                w_addend   = ~b;
                w_carry    = 1'b1;
            end
            4'b0011: begin
                w_is_arith = 1'b1;
                w_addend   = ~b;
                w_carry    = ~cin;
            end
            4'b0100: w_res = a & b;
            4'b0101: w_res = a | b;
            4'b0110: w_res = a ^ b;
            4'b0111: w_res = ~a;
`ifdef ALU_NBIT_SHIFT_EN
            // A zero shift amount completes immediately with f = a.
            4'b1000, 4'b1001: begin
                w_is_shift = 1'b1;
                w_res      = a;
            end
`endif
            default: w_illegal = 1'b1;
        endcase
        w_sum = {1'b0, a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_carry};
        if (w_is_arith) begin
            w_res  = w_sum[WIDTH-1:0];
            w_cout = w_sum[WIDTH];
            w_ovf  = (a[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
        end
    end

    assign w_go_exec = w_is_shift && (w_shamt != '0);

    // One bit per cycle through the working register; w_shout is the bit falling off.
    always_comb begin
        if (r_shr) begin
            w_work_nxt = {1'b0, r_work[WIDTH-1:1]};
            w_shout    = r_work[0];
        end else begin
            w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
            w_shout    = r_work[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_load_single = 1'b0;
        w_start_shift = 1'b0;
        w_shift_step  = 1'b0;
        w_shift_done  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = !r_out_valid || out_ready;
                if (in_valid && w_in_ready) begin
                    if (w_go_exec) begin
                        w_start_shift = 1'b1;
                        w_state_nxt   = EXEC;
                    end else begin
                        w_load_single = 1'b1;
                    end
                end
            end
            EXEC: begin
                w_shift_step = 1'b1;
                if (r_cnt == SHW'(1)) begin
                    w_shift_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_f         <= '0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
            r_work      <= '0;
            r_cnt       <= '0;
            r_shr       <= 1'b0;
        end else begin
            if (w_load_single) begin
                r_out_valid <= 1'b1;
                r_f         <= w_res;
                r_cout      <= w_cout;
                // Illegal ops report every flag as 0, including zero.
                r_zero      <= !w_illegal && (w_res == '0);
                r_neg       <= w_res[WIDTH-1];
                r_ovf       <= w_ovf;
                r_illegal   <= w_illegal;
            end else if (w_shift_done) begin
                r_out_valid <= 1'b1;
                r_f         <= w_work_nxt;
                r_cout      <= w_shout;
                r_zero      <= (w_work_nxt == '0);
                r_neg       <= w_work_nxt[WIDTH-1];
                r_ovf       <= 1'b0;
                r_illegal   <= 1'b0;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_start_shift) begin
                r_work <= a;
                r_cnt  <= w_shamt;
                r_shr  <= op[0];
            end else if (w_shift_step) begin
                r_work <= w_work_nxt;
                r_cnt  <= r_cnt - SHW'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign f         = r_f;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign ovf       = r_ovf;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Directed bench for alu_nbit_seq at WIDTH=4; shift vectors follow ALU_NBIT_SHIFT_EN.
module tb_alu_nbit_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;
  logic         illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] f;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;
    logic         ill;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  logic [W+4:0] exp_q[$];

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic add(input logic [3:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                     input logic t_cin, input logic [W-1:0] t_f, input logic t_cout,
                     input logic t_zero, input logic t_neg, input logic t_ovf,
                     input logic t_ill, input int t_lat);
    vec_t v;
    v.op = t_op; v.a = t_a; v.b = t_b; v.cin = t_cin;
    v.f = t_f; v.cout = t_cout; v.zero = t_zero; v.neg = t_neg;
    v.ovf = t_ovf; v.ill = t_ill; v.lat = t_lat;
    vecs.push_back(v);
  endtask

  // driver: issue one op with out_ready high, score result and latency
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    logic [W+4:0] expv;
    logic [W+4:0] act;
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    exp_q.push_back({v.ill, v.ovf, v.neg, v.zero, v.cout, v.f});
    #1 chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1'b1;
      else chk($sformatf("v%0d_busy_in_ready", idx), 32'(in_ready), 32'd0);
    end
    if (!got) begin
      chk($sformatf("v%0d_timeout", idx), 32'(out_valid), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      expv = exp_q.pop_front();
      act = {illegal, ovf, neg, zero, cout, f};
      chk($sformatf("v%0d_op%b_{ill,ovf,neg,zero,cout,f}", idx, v.op), 32'(act), 32'(expv));
      chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_f"}, 32'(f), 32'd0);
    chk({tag, "_flags"}, 32'({cout, zero, neg, ovf, illegal}), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;

    // op, a, b, cin -> f, cout, zero, neg, ovf, illegal, latency
    add(4'b0001, 4'b0111, 4'b1001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(4'b0010, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(4'b0001, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    add(4'b0000, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(4'b0000, 4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    add(4'b0011, 4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(4'b0011, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    add(4'b0010, 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(4'b0100, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(4'b0101, 4'b1100, 4'b1010, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(4'b0110, 4'b1010, 4'b0110, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(4'b0111, 4'b0101, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(4'b0111, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(4'b1010, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(4'b1111, 4'b0101, 4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
`ifdef ALU_NBIT_SHIFT_EN
    add(4'b1000, 4'b0011, 4'b0010, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    add(4'b1001, 4'b1001, 4'b0001, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(4'b1000, 4'b0101, 4'b0000, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(4'b1001, 4'b1000, 4'b0011, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    add(4'b1000, 4'b1011, 4'b0111, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4);
    add(4'b1001, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2);
`else
    add(4'b1000, 4'b0011, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    add(4'b1001, 4'b1001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
`endif

    // reset state, during and after reset
    repeat (2) @(negedge clk);
    #1 chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk_idle_outputs("post_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_vec(v, i);
    end

    // back-pressure: result held, second op waits, accept + drain on the same edge
    @(negedge clk);
    out_ready = 1'b0;
    op = 4'b0001; a = 4'b0001; b = 4'b0001; cin = 1'b0; in_valid = 1'b1;
    #1 chk("bp_first_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    op = 4'b0110; a = 4'b1010; b = 4'b0110; cin = 1'b0;
    #1 chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_f_first", 32'(f), 32'h2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk($sformatf("bp_hold%0d", k), 32'({out_valid, in_ready, f}), 32'({1'b1, 1'b0, 4'b0010}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_same_cycle", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1 chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_f", 32'(f), 32'hC);
    chk("bp_second_flags", 32'({cout, zero, neg, ovf, illegal}), 32'b00100);
    out_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_drained", 32'(out_valid), 32'd0);

    // reset while a result is pending
    @(negedge clk);
    out_ready = 1'b0;
    op = 4'b0101; a = 4'b0011; b = 4'b0100; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rstpend_valid_before", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk_idle_outputs("rstpend");
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

`ifdef ALU_NBIT_SHIFT_EN
    // reset during EXEC of a 3-bit shift aborts it
    @(negedge clk);
    op = 4'b1000; a = 4'b0001; b = 4'b0011; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rstexec_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rstexec_out_valid", 32'(out_valid), 32'd0);
    chk("rstexec_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("rstexec_no_stale%0d", k), 32'({out_valid, in_ready}), 32'b01);
    end
`endif

    // normal operation after the reset sequences
    v = vecs[1];
    run_vec(v, 100);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
